// File: rtl/contador_pkg.sv
// contador_pkg: shared types and constants for the parameterised counter.
// Holds the count-mode enumeration and the width of its encoding.
package contador_pkg;

   localparam int MODO_W = 2;

   typedef enum logic [MODO_W-1:0] {
      MODO_SOBE   = 2'b00,
      MODO_DESCE  = 2'b01,
      MODO_VAIVEM = 2'b10,
      MODO_PARA   = 2'b11
   } modo_t;

endpackage

// File: rtl/contador_param.sv
// contador_param: bounded up/down/bounce counter with clamped load.
// Ports: clock, reset (async, high); enable, modo, carga, valor_carga,
// limite_min, limite_max in; saida, descendo, fim registered out.
module contador_param
   import contador_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int HOLD_AT_END = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [MODO_W-1:0] modo,
   input  logic             carga,
   input  logic [WIDTH-1:0] valor_carga,
   input  logic [WIDTH-1:0] limite_min,
   input  logic [WIDTH-1:0] limite_max,
   output logic [WIDTH-1:0] saida,
   output logic             descendo,
   output logic             fim
);

   localparam bit HOLD = (HOLD_AT_END != 0);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   modo_t            modo_sel;
   logic             bounds_ok;
   logic             at_top;
   logic             at_bot;
   logic             single;
   logic [WIDTH-1:0] saida_nxt;
   logic             desc_nxt;
   logic             fim_nxt;

   always_comb begin
      modo_sel  = modo_t'(modo);
      bounds_ok = (limite_min <= limite_max);
      // >= / <= rather than == so an out-of-range count is pulled back
      at_top    = (saida >= limite_max);
      at_bot    = (saida <= limite_min);
      single    = (limite_min == limite_max);
      saida_nxt = saida;
      desc_nxt  = descendo;
      fim_nxt   = 1'b0;

      if (!bounds_ok) begin
         // frozen until the bounds make sense again
      end else if (carga) begin
         if (valor_carga < limite_min)
            saida_nxt = limite_min;
         else if (valor_carga > limite_max)
            saida_nxt = limite_max;
         else
            saida_nxt = valor_carga;
      end else if (enable) begin
         unique case (modo_sel)
            MODO_SOBE: begin
               desc_nxt = 1'b0;
               if (at_top) begin
                  saida_nxt = limite_min;
                  fim_nxt   = 1'b1;
               end else begin
                  saida_nxt = saida + ONE;
               end
            end
            MODO_DESCE: begin
               desc_nxt = 1'b1;
               if (at_bot) begin
                  saida_nxt = limite_max;
                  fim_nxt   = 1'b1;
               end else begin
                  saida_nxt = saida - ONE;
               end
            end
            MODO_VAIVEM: begin
               if (!descendo) begin
                  if (at_top) begin
                     desc_nxt = 1'b1;
                     fim_nxt  = 1'b1;
                     // a one-value range has no neighbour to step to
                     if (single)
                        saida_nxt = limite_min;
                     else if (!HOLD)
                        saida_nxt = limite_max - ONE;
                  end else begin
                     saida_nxt = saida + ONE;
                  end
               end else begin
                  if (at_bot) begin
                     desc_nxt = 1'b0;
                     fim_nxt  = 1'b1;
                     if (single)
                        saida_nxt = limite_min;
                     else if (!HOLD)
                        saida_nxt = limite_min + ONE;
                  end else begin
                     saida_nxt = saida - ONE;
                  end
               end
            end
            MODO_PARA: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         saida    <= '0;
         descendo <= 1'b0;
         fim      <= 1'b0;
      end else begin
         saida    <= saida_nxt;
         descendo <= desc_nxt;
         fim      <= fim_nxt;
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: vector table, corner sequences and a randomized
// run against an arithmetic reference model, for both HOLD_AT_END values.
module tb_contador_param;

   localparam int W = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         enable;
   logic [1:0]   modo;
   logic         carga;
   logic [W-1:0] valor_carga;
   logic [W-1:0] limite_min;
   logic [W-1:0] limite_max;
   logic [W-1:0] saida_h, saida_n;
   logic         desc_h, desc_n;
   logic         fim_h, fim_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   contador_param #(.WIDTH(W), .HOLD_AT_END(1)) dut_hold (
      .clock(clock), .reset(reset), .enable(enable), .modo(modo),
      .carga(carga), .valor_carga(valor_carga),
      .limite_min(limite_min), .limite_max(limite_max),
      .saida(saida_h), .descendo(desc_h), .fim(fim_h)
   );

   contador_param #(.WIDTH(W), .HOLD_AT_END(0)) dut_nohold (
      .clock(clock), .reset(reset), .enable(enable), .modo(modo),
      .carga(carga), .valor_carga(valor_carga),
      .limite_min(limite_min), .limite_max(limite_max),
      .saida(saida_n), .descendo(desc_n), .fim(fim_n)
   );

   typedef struct {
      string name;
      bit    c;
      bit    e;
      bit [1:0] m;
      int    v;
      int    lo;
      int    hi;
      int    es;
      bit    ed;
      bit    ef;
   } vec_t;

   vec_t tbl[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(bit c, bit e, bit [1:0] m, int v, int lo, int hi);
      carga       = c;
      enable      = e;
      modo        = m;
      valor_carga = W'(v);
      limite_min  = W'(lo);
      limite_max  = W'(hi);
   endtask

   task automatic check_both(string name, int s, bit d, bit f);
      check({name, " saida"}, 32'(saida_h), s);
      check({name, " descendo"}, 32'(desc_h), 32'(d));
      check({name, " fim"}, 32'(fim_h), 32'(f));
      check({name, " saida(nh)"}, 32'(saida_n), s);
      check({name, " descendo(nh)"}, 32'(desc_n), 32'(d));
      check({name, " fim(nh)"}, 32'(fim_n), 32'(f));
   endtask

   // Next state straight from the behavioural rules, in plain integers.
   function automatic void ref_next(input bit hold, input int s, input bit d,
                                    output int ns, output bit nd,
                                    output bit nf);
      int lo;
      int hi;
      int v;
      lo = int'(limite_min);
      hi = int'(limite_max);
      v  = int'(valor_carga);
      ns = s;
      nd = d;
      nf = 1'b0;
      if (lo > hi) return;
      if (carga) begin
         ns = (v < lo) ? lo : ((v > hi) ? hi : v);
         return;
      end
      if (!enable) return;
      case (modo)
         2'd0: begin
            nd = 1'b0;
            if (s >= hi) begin ns = lo; nf = 1'b1; end
            else ns = s + 1;
         end
         2'd1: begin
            nd = 1'b1;
            if (s <= lo) begin ns = hi; nf = 1'b1; end
            else ns = s - 1;
         end
         2'd2: begin
            if (!d) begin
               if (s >= hi) begin
                  nd = 1'b1;
                  nf = 1'b1;
                  if (lo == hi) ns = lo;
                  else if (!hold) ns = hi - 1;
               end else ns = s + 1;
            end else begin
               if (s <= lo) begin
                  nd = 1'b0;
                  nf = 1'b1;
                  if (lo == hi) ns = lo;
                  else if (!hold) ns = lo + 1;
               end else ns = s - 1;
            end
         end
         default: ;
      endcase
   endfunction

   initial begin
      int seq[$];
      int prev;
      bit d;
      bit f;
      int s_h, s_n, ns;
      bit d_h, d_n, nd, nf, f_h, f_n;
      int lo, hi, t;

      reset = 1'b1;
      drive(0, 0, 2'd0, 0, 0, 15);
      #1;
      check_both("reset state", 0, 0, 0);
      tick();
      check_both("reset held over edge", 0, 0, 0);
      reset = 1'b0;

      // name, carga, enable, modo, valor, min, max, saida, descendo, fim
      tbl.push_back('{"load 3 in 3..5",    1, 1, 2'd0, 3, 3, 5, 3, 0, 0});
      tbl.push_back('{"up 4",              0, 1, 2'd0, 0, 3, 5, 4, 0, 0});
      tbl.push_back('{"up 5",              0, 1, 2'd0, 0, 3, 5, 5, 0, 0});
      tbl.push_back('{"up wrap to 3",      0, 1, 2'd0, 0, 3, 5, 3, 0, 1});
      tbl.push_back('{"up 4 after wrap",   0, 1, 2'd0, 0, 3, 5, 4, 0, 0});
      tbl.push_back('{"load 9 clamp 7",    1, 0, 2'd0, 9, 2, 7, 7, 0, 0});
      tbl.push_back('{"load 1 clamp 2",    1, 0, 2'd0, 1, 2, 7, 2, 0, 0});
      tbl.push_back('{"enable 0 freeze",   0, 0, 2'd0, 0, 2, 7, 2, 0, 0});
      tbl.push_back('{"down wrap to 7",    0, 1, 2'd1, 0, 2, 7, 7, 1, 1});
      tbl.push_back('{"down 6",            0, 1, 2'd1, 0, 2, 7, 6, 1, 0});
      tbl.push_back('{"enable 0 freeze 2", 0, 0, 2'd1, 0, 2, 7, 6, 1, 0});
      tbl.push_back('{"modo 11 freeze",    0, 1, 2'd3, 0, 2, 7, 6, 1, 0});
      tbl.push_back('{"bad bounds load",   1, 1, 2'd0, 3, 8, 4, 6, 1, 0});
      tbl.push_back('{"bad bounds up",     0, 1, 2'd0, 0, 8, 4, 6, 1, 0});
      tbl.push_back('{"above max to min",  0, 1, 2'd0, 0, 0, 4, 0, 0, 1});
      tbl.push_back('{"load into 5..5",    1, 1, 2'd2, 0, 5, 5, 5, 0, 0});
      tbl.push_back('{"single turn 1",     0, 1, 2'd2, 0, 5, 5, 5, 1, 1});
      tbl.push_back('{"single turn 2",     0, 1, 2'd2, 0, 5, 5, 5, 0, 1});
      tbl.push_back('{"single turn 3",     0, 1, 2'd2, 0, 5, 5, 5, 1, 1});

      foreach (tbl[i]) begin
         drive(tbl[i].c, tbl[i].e, tbl[i].m, tbl[i].v, tbl[i].lo, tbl[i].hi);
         tick();
         check_both(tbl[i].name, tbl[i].es, tbl[i].ed, tbl[i].ef);
      end

      // Full bounce sweep 0..15 with endpoint repeat.
      drive(0, 1, 2'd2, 0, 0, 15);
      reset = 1'b1;
      #1;
      check("bounce start saida", 32'(saida_h), 0);
      reset = 1'b0;
      for (int v = 1; v <= 15; v++) seq.push_back(v);
      seq.push_back(15);
      for (int v = 14; v >= 0; v--) seq.push_back(v);
      seq.push_back(0);
      seq.push_back(1);
      prev = 0;
      d = 1'b0;
      foreach (seq[i]) begin
         tick();
         f = (seq[i] == prev);
         if (f) d = ~d;
         check($sformatf("bounce[%0d] saida", i), 32'(saida_h), seq[i]);
         check($sformatf("bounce[%0d] descendo", i), 32'(desc_h), 32'(d));
         check($sformatf("bounce[%0d] fim", i), 32'(fim_h), 32'(f));
         prev = seq[i];
      end

      // Async reset in the middle of a down-wrap count.
      drive(1, 1, 2'd1, 6, 0, 9);
      tick();
      check_both("down load 6", 6, 0, 0);
      carga = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check_both("async reset mid count", 0, 0, 0);
      reset = 1'b0;
      tick();
      check_both("after reset wrap 9", 9, 1, 1);
      tick();
      check_both("after reset 8", 8, 1, 0);

      // Invalid bounds: ten enabled edges must not move anything.
      for (int i = 0; i < 10; i++) begin
         drive(i % 3 == 0, 1, 2'(i % 3), i, 8, 4);
         tick();
         check_both($sformatf("invalid bounds edge %0d", i), 8, 1, 0);
      end

      // Randomized run against the reference model.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      s_h = 0; d_h = 0; f_h = 0;
      s_n = 0; d_n = 0; f_n = 0;
      for (int i = 0; i < 600; i++) begin
         lo = int'($urandom_range(0, 15));
         hi = int'($urandom_range(0, 15));
         if (lo > hi && $urandom_range(0, 7) != 0) begin
            t = lo; lo = hi; hi = t;
         end
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
               2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), lo, hi);
         ref_next(1'b1, s_h, d_h, ns, nd, nf);
         s_h = ns; d_h = nd; f_h = nf;
         ref_next(1'b0, s_n, d_n, ns, nd, nf);
         s_n = ns; d_n = nd; f_n = nf;
         tick();
         check($sformatf("rand[%0d] saida", i), 32'(saida_h), s_h);
         check($sformatf("rand[%0d] descendo", i), 32'(desc_h), 32'(d_h));
         check($sformatf("rand[%0d] fim", i), 32'(fim_h), 32'(f_h));
         check($sformatf("rand[%0d] saida(nh)", i), 32'(saida_n), s_n);
         check($sformatf("rand[%0d] descendo(nh)", i), 32'(desc_n), 32'(d_n));
         check($sformatf("rand[%0d] fim(nh)", i), 32'(fim_n), 32'(f_n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
